// File: rtl/i2c_eeprom_slave_pkg.sv
// ---------------------------------------------------------------------------
// i2c_eeprom_slave_pkg
//  Shared definitions for the I2C EEPROM responder: FSM state encoding,
//  the R/W bit value meaning "read", the default 7-bit device address and a
//  helper that advances a pointer inside a write page.
// ---------------------------------------------------------------------------
package i2c_eeprom_slave_pkg;

  localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h50;
  localparam logic       I2C_RW_READ      = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_DEV     = 4'd1,
    ST_DEV_ACK = 4'd2,
    ST_WADDR   = 4'd3,
    ST_WA_ACK  = 4'd4,
    ST_WDATA   = 4'd5,
    ST_WD_ACK  = 4'd6,
    ST_RDATA   = 4'd7,
    ST_MACK    = 4'd8
  } state_e;

  // Increment only the in-page bits of ptr (mask = PAGE_SIZE-1); the page
  // number in the upper bits is kept, so page writes wrap inside the page.
  function automatic logic [7:0] page_inc(input logic [7:0] ptr,
                                          input logic [7:0] mask);
    logic [7:0] nxt;
    nxt = ptr + 8'd1;
    return (ptr & ~mask) | (nxt & mask);
  endfunction

endpackage

// File: rtl/i2c_eeprom_slave_filter.sv
// ---------------------------------------------------------------------------
// i2c_line_filter
//  Conditions one asynchronous I2C line: 2-FF synchroniser, then a glitch
//  filter whose output level only changes after FILT_LEN consecutive samples
//  disagree with it. Rise/fall strobes are one-cycle pulses asserted in the
//  same cycle the filtered level changes.
//  Ports:
//   CLK, RSTn  clock, asynchronous active-low reset
//   din        raw line input
//   level      filtered level (resets to 1, the idle bus level)
//   rise/fall  one-cycle edge strobes of the filtered level
// ---------------------------------------------------------------------------
module i2c_line_filter #(
  parameter int FILT_LEN = 3
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // cnt_q counts how many samples in a row have disagreed with level_q;
  // any agreeing sample restarts the count.
  always_comb begin
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(FILT_LEN - 1)) begin
        level_d = sync2_q;
        rise_d  = sync2_q;
        fall_d  = ~sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/i2c_eeprom_slave.sv
// ---------------------------------------------------------------------------
// i2c_eeprom_slave
//  I2C responder emulating a 256-byte 24C02-style EEPROM at DEV_ADDR.
//  SCL/SDA are oversampled on CLK; SDA is driven open-drain (0 or z).
//  Ports:
//   CLK, RSTn  system clock, asynchronous active-low reset
//   SCL        I2C clock from the master
//   SDA        I2C data, open-drain
//   Wr_En      one-cycle pulse when a data byte is committed to memory
//   Wr_Addr    address of the committed byte
//   Wr_Data    committed byte
//   Busy       high from START until STOP
// ---------------------------------------------------------------------------
module i2c_eeprom_slave
  import i2c_eeprom_slave_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR  = DEV_ADDR_DEFAULT,
  parameter int         PAGE_SIZE = 8,
  parameter int         FILT_LEN  = 3,
  parameter int         SDA_DLY   = 20
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       SCL,
  inout  wire        SDA,
  output logic       Wr_En,
  output logic [7:0] Wr_Addr,
  output logic [7:0] Wr_Data,
  output logic       Busy
);

  localparam logic [7:0] PAGE_MASK = 8'(PAGE_SIZE - 1);

  // ---------------- input conditioning ----------------
  logic sda_in;
  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  assign sda_in = SDA;

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
    .CLK  (CLK),
    .RSTn (RSTn),
    .din  (SCL),
    .level(scl_lvl),
    .rise (scl_rise),
    .fall (scl_fall)
  );

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
    .CLK  (CLK),
    .RSTn (RSTn),
    .din  (sda_in),
    .level(sda_lvl),
    .rise (sda_rise),
    .fall (sda_fall)
  );

  // Both lines pass through identical filters, so their relative timing is
  // preserved. scl_lvl is already high in the cycle scl_rise fires, which
  // makes a coincident SDA edge count as START/STOP rather than a data bit.
  logic start_det, stop_det;
  assign start_det = sda_fall & scl_lvl;
  assign stop_det  = sda_rise & scl_lvl;

  // ---------------- state ----------------
  state_e     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] ptr_q, ptr_d;
  logic       rw_q, rw_d;
  logic       ack_seen_q, ack_seen_d;   // ACK-bit SCL rise has passed
  logic       busy_q, busy_d;
  logic       sda_oe_q, sda_oe_d;       // 1 = pull SDA low
  logic       pend_q, pend_d;           // SDA value to apply when timer expires
  logic       dly_run_q, dly_run_d;
  logic [6:0] dly_cnt_q, dly_cnt_d;
  logic       wr_en_q, wr_en_d;
  logic [7:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;

  logic [7:0] mem [256];
  logic [7:0] rd_data_q;
  logic       mem_we;
  logic [7:0] byte_in;
  logic       sched;
  logic       sched_val;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    ptr_d      = ptr_q;
    rw_d       = rw_q;
    ack_seen_d = ack_seen_q;
    busy_d     = busy_q;
    sda_oe_d   = sda_oe_q;
    pend_d     = pend_q;
    dly_run_d  = dly_run_q;
    dly_cnt_d  = dly_cnt_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    mem_we     = 1'b0;
    sched      = 1'b0;
    sched_val  = 1'b0;
    byte_in    = {shift_q[6:0], sda_lvl};

    // SDA update timer: applies the value chosen at the last SCL fall. The
    // scl_lvl guard keeps SDA frozen should SCL already be high again.
    if (dly_run_q) begin
      if (dly_cnt_q == 7'd0) begin
        dly_run_d = 1'b0;
        if (!scl_lvl) begin
          sda_oe_d = pend_q;
        end
      end else begin
        dly_cnt_d = dly_cnt_q - 7'd1;
      end
    end

    if (start_det) begin
      state_d    = ST_DEV;
      bit_cnt_d  = 4'd0;
      ack_seen_d = 1'b0;
      busy_d     = 1'b1;
      sda_oe_d   = 1'b0;
      dly_run_d  = 1'b0;
    end else if (stop_det) begin
      state_d   = ST_IDLE;
      busy_d    = 1'b0;
      sda_oe_d  = 1'b0;
      dly_run_d = 1'b0;
    end else begin
      case (state_q)
        ST_DEV, ST_WADDR, ST_WDATA: begin
          if (scl_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d  = 4'd0;
              ack_seen_d = 1'b0;
              if (state_q == ST_DEV) begin
                if (byte_in[7:1] == DEV_ADDR) begin
                  state_d = ST_DEV_ACK;
                  rw_d    = byte_in[0];
                end else begin
                  state_d = ST_IDLE;
                end
              end else if (state_q == ST_WADDR) begin
                ptr_d   = byte_in;
                state_d = ST_WA_ACK;
              end else begin
                mem_we    = 1'b1;
                wr_en_d   = 1'b1;
                wr_addr_d = ptr_q;
                wr_data_d = byte_in;
                ptr_d     = page_inc(ptr_q, PAGE_MASK);
                state_d   = ST_WD_ACK;
              end
            end
          end else if (scl_fall) begin
            sched = 1'b1;
          end
        end

        // The fall before the ACK bit starts pulling SDA low; the fall
        // after it hands the bus to the next phase.
        ST_DEV_ACK, ST_WA_ACK, ST_WD_ACK: begin
          if (scl_rise) begin
            ack_seen_d = 1'b1;
          end else if (scl_fall) begin
            sched = 1'b1;
            if (!ack_seen_q) begin
              sched_val = 1'b1;
            end else begin
              bit_cnt_d = 4'd0;
              if (state_q == ST_DEV_ACK && rw_q == I2C_RW_READ) begin
                state_d   = ST_RDATA;
                shift_d   = rd_data_q;
                sched_val = ~rd_data_q[7];
              end else if (state_q == ST_DEV_ACK) begin
                state_d = ST_WADDR;
              end else begin
                state_d = ST_WDATA;
              end
            end
          end
        end

        ST_RDATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            sched = 1'b1;
            if (bit_cnt_q == 4'd8) begin
              state_d    = ST_MACK;
              bit_cnt_d  = 4'd0;
              ack_seen_d = 1'b0;
            end else begin
              shift_d   = {shift_q[6:0], 1'b0};
              sched_val = ~shift_q[6];
            end
          end
        end

        // rd_data_q follows mem[ptr_q] one cycle late, so the byte at the
        // incremented pointer is ready by the following SCL fall.
        ST_MACK: begin
          if (scl_rise) begin
            if (!sda_lvl) begin
              ptr_d      = ptr_q + 8'd1;
              ack_seen_d = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end else if (scl_fall && ack_seen_q) begin
            state_d   = ST_RDATA;
            bit_cnt_d = 4'd0;
            shift_d   = rd_data_q;
            sched     = 1'b1;
            sched_val = ~rd_data_q[7];
          end
        end

        default: ;
      endcase
    end

    if (sched) begin
      pend_d    = sched_val;
      dly_cnt_d = 7'(SDA_DLY);
      dly_run_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 4'd0;
      shift_q    <= 8'd0;
      ptr_q      <= 8'd0;
      rw_q       <= 1'b0;
      ack_seen_q <= 1'b0;
      busy_q     <= 1'b0;
      sda_oe_q   <= 1'b0;
      pend_q     <= 1'b0;
      dly_run_q  <= 1'b0;
      dly_cnt_q  <= 7'd0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= 8'd0;
      wr_data_q  <= 8'd0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      rw_q       <= rw_d;
      ack_seen_q <= ack_seen_d;
      busy_q     <= busy_d;
      sda_oe_q   <= sda_oe_d;
      pend_q     <= pend_d;
      dly_run_q  <= dly_run_d;
      dly_cnt_q  <= dly_cnt_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  // Memory contents survive reset; one write port, one registered read port.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem[ptr_q] <= byte_in;
    end
    rd_data_q <= mem[ptr_q];
  end

  assign SDA     = sda_oe_q ? 1'b0 : 1'bz;
  assign Wr_En   = wr_en_q;
  assign Wr_Addr = wr_addr_q;
  assign Wr_Data = wr_data_q;
  assign Busy    = busy_q;

endmodule

// File: tb/tb_i2c_eeprom_slave.sv
module tb_i2c_eeprom_slave;

  logic       CLK = 1'b0;
  logic       RSTn = 1'b0;
  logic       scl_drv = 1'b1;
  logic       m_sda_oe = 1'b0;
  wire        SDA;
  logic       Wr_En;
  logic [7:0] Wr_Addr;
  logic [7:0] Wr_Data;
  logic       Busy;

  int checks = 0;
  int errors = 0;

  logic [15:0] wr_log [$];

  assign SDA = m_sda_oe ? 1'b0 : 1'bz;
  pullup (SDA);

  always #5 CLK = ~CLK;

  i2c_eeprom_slave dut (
    .CLK    (CLK),
    .RSTn   (RSTn),
    .SCL    (scl_drv),
    .SDA    (SDA),
    .Wr_En  (Wr_En),
    .Wr_Addr(Wr_Addr),
    .Wr_Data(Wr_Data),
    .Busy   (Busy)
  );

  always @(posedge CLK) begin
    if (Wr_En === 1'b1) wr_log.push_back({Wr_Addr, Wr_Data});
  end

  // ---------------- bus helpers ----------------
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  function automatic logic sda_bit();
    return (SDA === 1'b0) ? 1'b0 : 1'b1;
  endfunction

  task automatic i2c_start();
    if (!scl_drv) begin
      wait_cyc(30); m_sda_oe = 1'b0;
      wait_cyc(90); scl_drv = 1'b1;
    end
    wait_cyc(30); m_sda_oe = 1'b1;
    wait_cyc(30); scl_drv = 1'b0;
  endtask

  task automatic i2c_stop();
    wait_cyc(30); m_sda_oe = 1'b1;
    wait_cyc(90); scl_drv = 1'b1;
    wait_cyc(30); m_sda_oe = 1'b0;
    wait_cyc(30);
  endtask

  task automatic write_bit(input logic b);
    wait_cyc(30); m_sda_oe = ~b;
    wait_cyc(90); scl_drv = 1'b1;
    wait_cyc(60); scl_drv = 1'b0;
  endtask

  task automatic read_bit(output logic b);
    wait_cyc(30); m_sda_oe = 1'b0;
    wait_cyc(70); b = sda_bit();
    wait_cyc(20); scl_drv = 1'b1;
    wait_cyc(60); scl_drv = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(input logic master_ack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(~master_ack);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RSTn = 1'b0;
    wait_cyc(5);
    RSTn = 1'b1;
    wait_cyc(10);
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", Busy); end
    checks++; if (Wr_En !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %b want 0", Wr_En); end
    checks++; if (Wr_Addr !== 8'h00) begin errors++; $display("FAIL reset_wr_addr got %h want 00", Wr_Addr); end
    checks++; if (Wr_Data !== 8'h00) begin errors++; $display("FAIL reset_wr_data got %h want 00", Wr_Data); end
    checks++; if (sda_bit() !== 1'b1) begin errors++; $display("FAIL reset_sda got %b want 1", sda_bit()); end
    $display("reset: Busy=%b Wr_En=%b SDA=%b", Busy, Wr_En, sda_bit());
  endtask

  task automatic test_write();
    logic a0, a1, a2;
    i2c_start();
    write_byte(8'hA0, a0);
    write_byte(8'h05, a1);
    write_byte(8'h1A, a2);
    checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL write_busy got %b want 1", Busy); end
    i2c_stop();
    checks++; if ({a0, a1, a2} !== 3'b000) begin errors++; $display("FAIL write_acks got %b want 000", {a0, a1, a2}); end
    checks++; if (wr_log.size() != 1) begin errors++; $display("FAIL write_count got %0d want 1", wr_log.size()); end
    checks++; if (Wr_Addr !== 8'h05) begin errors++; $display("FAIL write_addr got %h want 05", Wr_Addr); end
    checks++; if (Wr_Data !== 8'h1A) begin errors++; $display("FAIL write_data got %h want 1a", Wr_Data); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL write_busy_after_stop got %b want 0", Busy); end
    $display("write: S A0 05 1A P acks=%b writes=%0d", {a0, a1, a2}, wr_log.size());
  endtask

  task automatic test_random_read();
    logic a0, a1, a2;
    logic [7:0] d;
    i2c_start();
    write_byte(8'hA0, a0);
    write_byte(8'h05, a1);
    i2c_start();
    write_byte(8'hA1, a2);
    read_byte(1'b0, d);
    wait_cyc(60);
    checks++; if (sda_bit() !== 1'b1) begin errors++; $display("FAIL rread_sda_released got %b want 1", sda_bit()); end
    i2c_stop();
    checks++; if ({a0, a1, a2} !== 3'b000) begin errors++; $display("FAIL rread_acks got %b want 000", {a0, a1, a2}); end
    checks++; if (d !== 8'h1A) begin errors++; $display("FAIL rread_data got %h want 1a", d); end
    checks++; if (wr_log.size() != 1) begin errors++; $display("FAIL rread_no_write got %0d want 1", wr_log.size()); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL rread_busy got %b want 0", Busy); end
    $display("random read: S A0 05 Sr A1 -> %h NACK P", d);
  endtask

  task automatic test_page_write();
    logic a, acks;
    logic [7:0] exp_addr [10] = '{8'h06, 8'h07, 8'h00, 8'h01, 8'h02,
                                  8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
    acks = 1'b0;
    i2c_start();
    write_byte(8'hA0, a); acks |= a;
    write_byte(8'h06, a); acks |= a;
    for (int i = 0; i < 10; i++) begin
      write_byte(8'(i), a);
      acks |= a;
    end
    i2c_stop();
    checks++; if (acks !== 1'b0) begin errors++; $display("FAIL page_acks got %b want 0", acks); end
    checks++; if (wr_log.size() != 11) begin errors++; $display("FAIL page_count got %0d want 11", wr_log.size()); end
    if (wr_log.size() == 11) begin
      for (int i = 0; i < 10; i++) begin
        checks++;
        if (wr_log[1 + i] !== {exp_addr[i], 8'(i)}) begin
          errors++;
          $display("FAIL page_entry%0d got %h want %h", i, wr_log[1 + i], {exp_addr[i], 8'(i)});
        end
      end
    end
    $display("page write: S A0 06 00..09 P writes=%0d", wr_log.size());
  endtask

  task automatic test_seq_read();
    logic a, acks;
    logic [7:0] d0, d1, d2;
    acks = 1'b0;
    i2c_start();
    write_byte(8'hA0, a); acks |= a;
    write_byte(8'hFE, a); acks |= a;
    write_byte(8'hAB, a); acks |= a;
    write_byte(8'hCD, a); acks |= a;
    i2c_stop();
    checks++; if (wr_log.size() != 13 || wr_log[12] !== 16'hFFCD) begin
      errors++; $display("FAIL seq_setup_write got size %0d want 13 with last ffcd", wr_log.size());
    end
    i2c_start();
    write_byte(8'hA0, a); acks |= a;
    write_byte(8'hFE, a); acks |= a;
    i2c_start();
    write_byte(8'hA1, a); acks |= a;
    read_byte(1'b1, d0);
    read_byte(1'b1, d1);
    read_byte(1'b0, d2);
    i2c_stop();
    checks++; if (acks !== 1'b0) begin errors++; $display("FAIL seq_acks got %b want 0", acks); end
    checks++; if (d0 !== 8'hAB) begin errors++; $display("FAIL seq_fe got %h want ab", d0); end
    checks++; if (d1 !== 8'hCD) begin errors++; $display("FAIL seq_ff got %h want cd", d1); end
    checks++; if (d2 !== 8'h02) begin errors++; $display("FAIL seq_00 got %h want 02", d2); end
    $display("seq read: from FE -> %h %h %h", d0, d1, d2);
  endtask

  task automatic test_nack_addr();
    logic a;
    i2c_start();
    write_byte(8'hA2, a);
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL nack_addr_ack got %b want 1", a); end
    checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL nack_busy_before_stop got %b want 1", Busy); end
    i2c_stop();
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL nack_busy_after_stop got %b want 0", Busy); end
    scl_drv = 1'b0; wait_cyc(5); scl_drv = 1'b1; wait_cyc(20);
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL scl_glitch_busy got %b want 0", Busy); end
    m_sda_oe = 1'b1; wait_cyc(2); m_sda_oe = 1'b0; wait_cyc(20);
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL sda_glitch_busy got %b want 0", Busy); end
    checks++; if (wr_log.size() != 13) begin errors++; $display("FAIL nack_no_write got %0d want 13", wr_log.size()); end
    $display("addr A2: ack=%b, glitches ignored Busy=%b", a, Busy);
  endtask

  task automatic test_reset_mid_read();
    logic a0, a1, a2, a3;
    i2c_start();
    write_byte(8'hA0, a0);
    write_byte(8'h00, a1);
    i2c_start();
    write_byte(8'hA1, a2);
    wait_cyc(60);
    checks++; if (sda_bit() !== 1'b0) begin errors++; $display("FAIL rst_mid_driving got %b want 0", sda_bit()); end
    RSTn = 1'b0;
    #1;
    checks++; if (sda_bit() !== 1'b1) begin errors++; $display("FAIL rst_mid_sda got %b want 1", sda_bit()); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b want 0", Busy); end
    wait_cyc(5);
    RSTn = 1'b1;
    wait_cyc(10);
    i2c_start();
    write_byte(8'hA0, a3);
    i2c_stop();
    checks++; if ({a0, a1, a2} !== 3'b000) begin errors++; $display("FAIL rst_mid_setup_acks got %b want 000", {a0, a1, a2}); end
    checks++; if (a3 !== 1'b0) begin errors++; $display("FAIL rst_after_ack got %b want 0", a3); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL rst_after_busy got %b want 0", Busy); end
    $display("reset mid-read: SDA released, then S A0 ack=%b", a3);
  endtask

  initial begin
    test_reset();
    test_write();
    test_random_read();
    test_page_write();
    test_seq_read();
    test_nack_addr();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
